// File: rtl/cnn_mem_pkg.sv
// cnn_mem_pkg
// Shared definitions for the CNN result-memory blocks:
//   - bank_state_t     : ownership state of one ping-pong bank
//   - ERR_* constants  : bit positions inside err_flags
//   - DEFAULT_*        : default word width and frame geometry
//   - bank_addr()      : row/column to linear word address, full 32-bit width
package cnn_mem_pkg;

  typedef enum logic {
    BANK_EMPTY = 1'b0,  // owned by the writer
    BANK_FULL  = 1'b1   // owned by the reader
  } bank_state_t;

  localparam int ERR_READ_UNDERFLOW = 0;
  localparam int ERR_WRITE_OVERFLOW = 1;
  localparam int ERR_ADDR_RANGE     = 2;

  localparam int DEFAULT_DATA_W = 128;
  localparam int DEFAULT_ROW_W  = 14;
  localparam int DEFAULT_ROWS   = 14;

  // Computed at 32 bits so a large row index cannot wrap into a legal
  // address before the range check sees it.
  function automatic logic [31:0] bank_addr(input logic [15:0] row,
                                             input logic [15:0] col,
                                             input logic [31:0] row_w);
    return (32'(row) * row_w) + 32'(col);
  endfunction

endpackage

// File: rtl/layer_result_bank.sv
// layer_result_bank
// One 1-write/1-read synchronous word array with a single-cycle registered
// read. Contents are never reset, so it maps onto block RAM or can be swapped
// for an SRAM macro wrapper with the same ports.
//   clk     : clock (posedge)
//   wr_en   : write strobe
//   wr_addr : write word address
//   wr_data : write data
//   rd_en   : read strobe; rd_data updates on the next edge
//   rd_addr : read word address
//   rd_data : registered read data (holds when rd_en=0)
module layer_result_bank
  import cnn_mem_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int DEPTH  = DEFAULT_ROWS * DEFAULT_ROW_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_reg[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data_reg <= mem_reg[rd_addr];
    end
  end

  assign rd_data = rd_data_reg;

endmodule

// File: rtl/layer_result_pingpong_mem.sv
// layer_result_pingpong_mem
// Two-bank ping-pong buffer between a layer writer and a layer reader. Each
// bank is either EMPTY (writer owns it) or FULL (reader owns it); the writer
// closes a frame with frame_save_done, the reader releases it with
// frame_read_done, and each side then moves to the other bank.
//   clk, rst         : clock, asynchronous active-high reset
//   save_*           : write strobe, row/column address, data
//   frame_save_done  : writer finished the current bank
//   read_signal      : read strobe with read_row_addr/read_col_addr
//   frame_read_done  : reader finished the current bank
//   read_data_out    : read data, one cycle after acceptance, 0 when invalid
//   read_valid       : read_data_out is valid
//   save_ready       : writer's bank is EMPTY
//   read_ready       : reader's bank is FULL
//   err_flags        : sticky {addr_range, write_overflow, read_underflow}
module layer_result_pingpong_mem
  import cnn_mem_pkg::*;
#(
  parameter int DATA_W = DEFAULT_DATA_W,
  parameter int ROW_W  = DEFAULT_ROW_W,
  parameter int ROWS   = DEFAULT_ROWS,
  parameter int DEPTH  = ROWS * ROW_W,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              save_enable,
  input  logic [15:0]       save_row_addr,
  input  logic [15:0]       save_col_addr,
  input  logic [DATA_W-1:0] save_data_in,
  input  logic              frame_save_done,
  input  logic              read_signal,
  input  logic [15:0]       read_row_addr,
  input  logic [15:0]       read_col_addr,
  input  logic              frame_read_done,
  output logic [DATA_W-1:0] read_data_out,
  output logic              read_valid,
  output logic              save_ready,
  output logic              read_ready,
  output logic [2:0]        err_flags
);

  bank_state_t bank_state_reg  [2];
  bank_state_t bank_state_next [2];
  logic        wr_bank_reg, wr_bank_next;
  logic        rd_bank_reg, rd_bank_next;
  logic [2:0]  err_reg, err_next;
  logic        read_valid_reg;
  logic        rd_sel_reg;   // bank that served the read now on the output

  logic [31:0] wr_addr_full, rd_addr_full;
  logic        wr_in_range, rd_in_range;
  logic        wr_bank_empty, rd_bank_full;
  logic        wr_en, rd_en;

  logic [1:0][DATA_W-1:0] bank_rd_data;

  assign wr_addr_full  = bank_addr(save_row_addr, save_col_addr, 32'(ROW_W));
  assign rd_addr_full  = bank_addr(read_row_addr, read_col_addr, 32'(ROW_W));
  assign wr_in_range   = (wr_addr_full < 32'(DEPTH));
  assign rd_in_range   = (rd_addr_full < 32'(DEPTH));
  assign wr_bank_empty = (bank_state_reg[wr_bank_reg] == BANK_EMPTY);
  assign rd_bank_full  = (bank_state_reg[rd_bank_reg] == BANK_FULL);

  // Bank ownership, pointers and error flags. The writer's bank is always
  // EMPTY-gated and the reader's FULL-gated, so the two handoffs below can
  // never target the same bank in one cycle.
  always_comb begin
    bank_state_next = bank_state_reg;
    wr_bank_next    = wr_bank_reg;
    rd_bank_next    = rd_bank_reg;
    err_next        = err_reg;
    wr_en           = 1'b0;
    rd_en           = 1'b0;

    if (save_enable) begin
      if (!wr_bank_empty) begin
        err_next[ERR_WRITE_OVERFLOW] = 1'b1;
      end else if (!wr_in_range) begin
        err_next[ERR_ADDR_RANGE] = 1'b1;
      end else begin
        wr_en = 1'b1;
      end
    end

    // The write above still targets the old bank: wr_bank only moves at the edge.
    if (frame_save_done) begin
      if (wr_bank_empty) begin
        bank_state_next[wr_bank_reg] = BANK_FULL;
        wr_bank_next                 = ~wr_bank_reg;
      end else begin
        err_next[ERR_WRITE_OVERFLOW] = 1'b1;
      end
    end

    if (read_signal) begin
      if (!rd_bank_full) begin
        err_next[ERR_READ_UNDERFLOW] = 1'b1;
      end else if (!rd_in_range) begin
        err_next[ERR_ADDR_RANGE] = 1'b1;
      end else begin
        rd_en = 1'b1;
      end
    end

    // Releasing a bank the reader does not hold is silently ignored.
    if (frame_read_done && rd_bank_full) begin
      bank_state_next[rd_bank_reg] = BANK_EMPTY;
      rd_bank_next                 = ~rd_bank_reg;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_state_reg[0] <= BANK_EMPTY;
      bank_state_reg[1] <= BANK_EMPTY;
      wr_bank_reg       <= 1'b0;
      rd_bank_reg       <= 1'b0;
      err_reg           <= 3'b000;
      read_valid_reg    <= 1'b0;
      rd_sel_reg        <= 1'b0;
    end else begin
      bank_state_reg    <= bank_state_next;
      wr_bank_reg       <= wr_bank_next;
      rd_bank_reg       <= rd_bank_next;
      err_reg           <= err_next;
      read_valid_reg    <= rd_en;
      if (rd_en) begin
        rd_sel_reg <= rd_bank_reg;
      end
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_bank
      layer_result_bank #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
      ) u_bank (
        .clk     (clk),
        .wr_en   (wr_en && (wr_bank_reg == 1'(gi))),
        .wr_addr (wr_addr_full[ADDR_W-1:0]),
        .wr_data (save_data_in),
        .rd_en   (rd_en && (rd_bank_reg == 1'(gi))),
        .rd_addr (rd_addr_full[ADDR_W-1:0]),
        .rd_data (bank_rd_data[gi])
      );
    end
  endgenerate

  // Bank outputs are unreset RAM registers; gating with read_valid keeps the
  // output at zero whenever it is not valid, including across reset.
  assign read_data_out = read_valid_reg ? bank_rd_data[rd_sel_reg] : '0;
  assign read_valid    = read_valid_reg;
  assign save_ready    = wr_bank_empty;
  assign read_ready    = rd_bank_full;
  assign err_flags     = err_reg;

endmodule

// File: tb/tb_layer_result_pingpong_mem.sv
// tb_layer_result_pingpong_mem
// Directed scenarios for the ping-pong result memory. Expected read data is
// pushed to a scoreboard queue when the read is driven and popped when
// read_valid is observed.
module tb_layer_result_pingpong_mem;

  localparam int DATA_W = 128;
  localparam int ROW_W  = 14;
  localparam int ROWS   = 14;
  localparam int DEPTH  = ROW_W * ROWS;

  logic              clk = 1'b0;
  logic              rst;
  logic              save_enable;
  logic [15:0]       save_row_addr, save_col_addr;
  logic [DATA_W-1:0] save_data_in;
  logic              frame_save_done;
  logic              read_signal;
  logic [15:0]       read_row_addr, read_col_addr;
  logic              frame_read_done;
  logic [DATA_W-1:0] read_data_out;
  logic              read_valid, save_ready, read_ready;
  logic [2:0]        err_flags;

  logic [DATA_W-1:0] exp_q [$];
  logic [DATA_W-1:0] exp_data;
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  layer_result_pingpong_mem dut (
    .clk             (clk),
    .rst             (rst),
    .save_enable     (save_enable),
    .save_row_addr   (save_row_addr),
    .save_col_addr   (save_col_addr),
    .save_data_in    (save_data_in),
    .frame_save_done (frame_save_done),
    .read_signal     (read_signal),
    .read_row_addr   (read_row_addr),
    .read_col_addr   (read_col_addr),
    .frame_read_done (frame_read_done),
    .read_data_out   (read_data_out),
    .read_valid      (read_valid),
    .save_ready      (save_ready),
    .read_ready      (read_ready),
    .err_flags       (err_flags)
  );

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    save_enable = 1'b0; save_row_addr = '0; save_col_addr = '0; save_data_in = '0;
    frame_save_done = 1'b0;
    read_signal = 1'b0; read_row_addr = '0; read_col_addr = '0;
    frame_read_done = 1'b0;
  endtask

  task automatic apply_reset();
    clear_inputs();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic set_write(input int r, input int c, input logic [DATA_W-1:0] d);
    save_enable = 1'b1; save_row_addr = 16'(r); save_col_addr = 16'(c); save_data_in = d;
  endtask

  task automatic set_read(input int r, input int c);
    read_signal = 1'b1; read_row_addr = 16'(r); read_col_addr = 16'(c);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    tick();
    checks++;
    if ({read_valid, save_ready, read_ready, err_flags} !== 6'b010000 || read_data_out !== '0) begin
      errors++;
      $display("FAIL reset_state: valid=%b save_ready=%b read_ready=%b err=%b data=%h, want 0 1 0 000 0",
               read_valid, save_ready, read_ready, err_flags, read_data_out);
    end
    rst = 1'b0;
    tick();
  endtask

  task automatic test_defaults();
    apply_reset();
    set_write(2, 3, {16{8'hA5}});
    tick();
    clear_inputs();
    frame_save_done = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (save_ready !== 1'b1 || read_ready !== 1'b1) begin
      errors++;
      $display("FAIL defaults_ready: save_ready=%b read_ready=%b, want 1 1", save_ready, read_ready);
    end
    set_read(2, 3);
    exp_q.push_back({16{8'hA5}});
    tick();
    clear_inputs();
    checks++;
    if (read_valid !== 1'b1) begin
      errors++;
      $display("FAIL defaults_valid: read_valid=%b, want 1", read_valid);
    end else begin
      exp_data = exp_q.pop_front();
      if (read_data_out !== exp_data) begin
        errors++;
        $display("FAIL defaults_data: got %h, want %h", read_data_out, exp_data);
      end
    end
    tick();
    checks++;
    if (read_valid !== 1'b0 || read_data_out !== '0) begin
      errors++;
      $display("FAIL defaults_idle: valid=%b data=%h, want 0 and 0", read_valid, read_data_out);
    end
    $display("defaults: write (2,3) addr 31, read back, err=%b", err_flags);
  endtask

  task automatic test_pingpong();
    apply_reset();
    for (int a = 0; a < DEPTH; a++) begin
      set_write(a / ROW_W, a % ROW_W, DATA_W'(a));
      tick();
    end
    clear_inputs();
    frame_save_done = 1'b1;
    tick();
    clear_inputs();
    // Fill bank1 while streaming bank0 out one read per cycle; the last
    // write shares its cycle with frame_save_done and must land in bank1.
    for (int a = 0; a < DEPTH; a++) begin
      set_write(a / ROW_W, a % ROW_W, DATA_W'(a + 1000));
      set_read(a / ROW_W, a % ROW_W);
      frame_save_done = (a == DEPTH - 1);
      exp_q.push_back(DATA_W'(a));
      tick();
      checks++;
      if (read_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL pingpong_bank0_valid[%0d]: read_valid=%b, want 1", a, read_valid);
        exp_q.delete();
      end else begin
        exp_data = exp_q.pop_front();
        if (read_data_out !== exp_data) begin
          errors++;
          $display("FAIL pingpong_bank0[%0d]: got %0d, want %0d", a, read_data_out, exp_data);
        end
      end
    end
    clear_inputs();
    // Release bank0 with a read in the same cycle: it still returns bank0 data.
    set_read(0, 5);
    frame_read_done = 1'b1;
    exp_q.push_back(DATA_W'(5));
    tick();
    clear_inputs();
    checks++;
    if (read_valid !== 1'b1 || read_data_out !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL pingpong_release_read: valid=%b data=%0d, want 1 and 5", read_valid, read_data_out);
    end
    for (int a = 0; a < DEPTH; a++) begin
      set_read(a / ROW_W, a % ROW_W);
      exp_q.push_back(DATA_W'(a + 1000));
      tick();
      checks++;
      if (read_valid !== 1'b1 || exp_q.size() == 0) begin
        errors++;
        $display("FAIL pingpong_bank1_valid[%0d]: read_valid=%b, want 1", a, read_valid);
        exp_q.delete();
      end else begin
        exp_data = exp_q.pop_front();
        if (read_data_out !== exp_data) begin
          errors++;
          $display("FAIL pingpong_bank1[%0d]: got %0d, want %0d", a, read_data_out, exp_data);
        end
      end
    end
    clear_inputs();
    checks++;
    if (err_flags !== 3'b000) begin
      errors++;
      $display("FAIL pingpong_err: err_flags=%b, want 000", err_flags);
    end
    $display("pingpong: %0d bank0 reads and %0d bank1 reads streamed, err=%b", DEPTH, DEPTH, err_flags);
  endtask

  task automatic test_overflow();
    apply_reset();
    set_write(0, 5, DATA_W'(32'h55));
    frame_save_done = 1'b1;
    tick();
    clear_inputs();
    set_write(0, 5, DATA_W'(32'h66));
    frame_save_done = 1'b1;
    tick();
    clear_inputs();
    checks++;
    if (save_ready !== 1'b0) begin
      errors++;
      $display("FAIL overflow_save_ready: save_ready=%b, want 0", save_ready);
    end
    set_write(0, 5, DATA_W'(32'hDEAD));
    tick();
    clear_inputs();
    checks++;
    if (err_flags !== 3'b010) begin
      errors++;
      $display("FAIL overflow_err: err_flags=%b, want 010", err_flags);
    end
    set_read(0, 5);
    frame_read_done = 1'b1;
    exp_q.push_back(DATA_W'(32'h55));
    tick();
    clear_inputs();
    checks++;
    if (read_valid !== 1'b1 || read_data_out !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL overflow_bank0_kept: valid=%b data=%h, want 1 and 55", read_valid, read_data_out);
    end
    set_read(0, 5);
    exp_q.push_back(DATA_W'(32'h66));
    tick();
    clear_inputs();
    checks++;
    if (read_valid !== 1'b1 || read_data_out !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL overflow_bank1_kept: valid=%b data=%h, want 1 and 66", read_valid, read_data_out);
    end
    $display("overflow: dropped write with both banks full, err=%b", err_flags);
  endtask

  task automatic test_underflow_range();
    // Out-of-range read on a FULL bank.
    apply_reset();
    frame_save_done = 1'b1;
    tick();
    clear_inputs();
    set_read(14, 0);
    tick();
    clear_inputs();
    checks++;
    if (read_valid !== 1'b0 || read_data_out !== '0 || err_flags !== 3'b100) begin
      errors++;
      $display("FAIL range_read: valid=%b data=%h err=%b, want 0 0 100", read_valid, read_data_out, err_flags);
    end
    // Read with nothing FULL, then out-of-range write.
    apply_reset();
    checks++;
    if (read_ready !== 1'b0) begin
      errors++;
      $display("FAIL underflow_ready: read_ready=%b, want 0", read_ready);
    end
    set_read(0, 0);
    tick();
    clear_inputs();
    checks++;
    if (read_valid !== 1'b0 || read_data_out !== '0 || err_flags !== 3'b001) begin
      errors++;
      $display("FAIL underflow: valid=%b data=%h err=%b, want 0 0 001", read_valid, read_data_out, err_flags);
    end
    set_write(14, 0, DATA_W'(32'hBAD));
    tick();
    clear_inputs();
    checks++;
    if (err_flags !== 3'b101 || save_ready !== 1'b1) begin
      errors++;
      $display("FAIL range_write: err=%b save_ready=%b, want 101 1", err_flags, save_ready);
    end
    tick();
    checks++;
    if (err_flags !== 3'b101) begin
      errors++;
      $display("FAIL err_sticky: err=%b, want 101", err_flags);
    end
    $display("underflow_range: err=%b", err_flags);
  endtask

  task automatic test_simultaneous();
    apply_reset();
    frame_save_done = 1'b1;           // bank0 FULL, writer moves to bank1
    tick();
    clear_inputs();
    set_write(0, 7, DATA_W'(32'hB1)); // lands in bank1
    tick();
    clear_inputs();
    frame_save_done = 1'b1;           // bank1 FULL, writer back to bank0
    frame_read_done = 1'b1;           // bank0 EMPTY, reader to bank1
    tick();
    clear_inputs();
    checks++;
    if (save_ready !== 1'b1 || read_ready !== 1'b1 || err_flags !== 3'b000) begin
      errors++;
      $display("FAIL simul_flags: save_ready=%b read_ready=%b err=%b, want 1 1 000",
               save_ready, read_ready, err_flags);
    end
    set_read(0, 7);
    exp_q.push_back(DATA_W'(32'hB1));
    tick();
    clear_inputs();
    checks++;
    if (read_valid !== 1'b1 || read_data_out !== exp_q.pop_front()) begin
      errors++;
      $display("FAIL simul_read_bank1: valid=%b data=%h, want 1 and b1", read_valid, read_data_out);
    end
    frame_save_done = 1'b1;           // bank0 FULL, writer to bank1 (still FULL)
    tick();
    clear_inputs();
    checks++;
    if (save_ready !== 1'b0 || err_flags !== 3'b000) begin
      errors++;
      $display("FAIL simul_wr_bank0: save_ready=%b err=%b, want 0 000", save_ready, err_flags);
    end
    $display("simultaneous: both handoffs on one edge, err=%b", err_flags);
  endtask

  task automatic test_reset_mid_read();
    apply_reset();
    set_write(1, 1, DATA_W'(32'h11));
    frame_save_done = 1'b1;
    tick();
    clear_inputs();
    set_read(1, 1);
    tick();                           // read accepted at this edge
    clear_inputs();
    checks++;
    if (read_valid !== 1'b1 || read_data_out !== DATA_W'(32'h11)) begin
      errors++;
      $display("FAIL midread_pre: valid=%b data=%h, want 1 and 11", read_valid, read_data_out);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (read_valid !== 1'b0 || read_data_out !== '0 || save_ready !== 1'b1 || read_ready !== 1'b0) begin
      errors++;
      $display("FAIL midread_reset: valid=%b data=%h save_ready=%b read_ready=%b, want 0 0 1 0",
               read_valid, read_data_out, save_ready, read_ready);
    end
    tick();
    rst = 1'b0;
    tick();
    checks++;
    if (read_valid !== 1'b0 || read_data_out !== '0) begin
      errors++;
      $display("FAIL midread_after: valid=%b data=%h, want 0 0", read_valid, read_data_out);
    end
    $display("reset_mid_read: pipelined read discarded, valid=%b", read_valid);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_defaults();
    test_pingpong();
    test_overflow();
    test_underflow_range();
    test_simultaneous();
    test_reset_mid_read();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
